audio_record_controller: RTL and testbench

Top-level sequencer for the audio recorder. Gates the PDM deserializer during record, writes each completed 16-bit word into a single-port sample RAM, and paces reads from that RAM during playback to feed the audio output stage. Sits between the debounced record/play button pulses, the deserializer, the sample RAM and the playback PWM block.

---
 rtl/audio_pkg.sv | 14 +
 rtl/playback_pacer.sv | 64 ++++++
 rtl/audio_record_controller.sv | 160 ++++++++++++++++
 tb/tb_audio_record_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio recorder blocks (controller, deserializer, PWM).
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } ctrl_state_t;

  localparam int unsigned SAMPLE_WIDTH        = 16;
  localparam int unsigned ADDR_WIDTH_DEFAULT  = 17;
  localparam int unsigned WORD_PERIOD_DEFAULT = 16;

endpackage

// File: rtl/playback_pacer.sv
// Playback read pacing: one read strobe every WORD_PERIOD cycles, walking addresses
// 0..length-1, with a flag marking the final read.
module playback_pacer #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned WORD_PERIOD = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  read_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam int unsigned CountWidth = (WORD_PERIOD > 1) ? $clog2(WORD_PERIOD) : 1;
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(WORD_PERIOD - 1);

  logic [CountWidth-1:0] count_q;
  logic [ADDR_WIDTH:0]   next_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q;
  logic                  last_q;
  logic                  fire;

  always_comb begin
    fire = enable_i && (count_q == CountMax) && (next_q < length_i);
  end

  // Clearing preloads the counter at its terminal value so the first read fires
  // on the first enabled cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
      next_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear_i) begin
      count_q <= CountMax;
      next_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (enable_i) begin
      count_q <= (count_q == CountMax) ? '0 : count_q + CountWidth'(1);
      read_q  <= fire;
      last_q  <= fire && (next_q == length_i - (ADDR_WIDTH + 1)'(1));
      if (fire) begin
        addr_q <= next_q[ADDR_WIDTH-1:0];
        next_q <= next_q + (ADDR_WIDTH + 1)'(1);
      end
    end else begin
      read_q <= 1'b0;
      last_q <= 1'b0;
    end
  end

  assign read_o = read_q;
  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/audio_record_controller.sv
// Recorder sequencer: gates the deserializer and writes its words to RAM while recording,
// then paces RAM reads into the playback sample stream.
module audio_record_controller
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int unsigned WORD_PERIOD = WORD_PERIOD_DEFAULT
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    record_i,
  input  logic                    play_i,
  output logic                    deser_enable_o,
  input  logic                    deser_done_i,
  input  logic [SAMPLE_WIDTH-1:0] deser_data_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [SAMPLE_WIDTH-1:0] mem_wdata_o,
  output logic                    mem_re_o,
  input  logic [SAMPLE_WIDTH-1:0] mem_rdata_i,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    sample_valid_o,
  output logic                    recording_o,
  output logic                    playing_o,
  output logic [ADDR_WIDTH:0]     length_o
);

  localparam logic [ADDR_WIDTH:0] LastAddr = {1'b0, {ADDR_WIDTH{1'b1}}};

  ctrl_state_t             state_q;
  logic [ADDR_WIDTH:0]     wr_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_hold_q;
  logic                    we_q;
  logic [SAMPLE_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH:0]     length_q;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic                    valid_q;
  logic                    rd_pend_q;
  logic                    rd_last_q;
  logic                    recording_q;
  logic                    playing_q;
  logic                    deser_en_q;

  logic                    start_rec;
  logic                    start_play;
  logic                    word_in;
  logic                    full;
  logic                    stop_rec;
  logic                    stop_btn;
  logic                    end_play;
  logic                    leave_play;
  logic                    pacer_en;
  logic                    rd_strobe;
  logic                    rd_last;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  always_comb begin
    start_rec  = (state_q == IDLE) && record_i;
    start_play = (state_q == IDLE) && !record_i && play_i && (length_q != '0);
    word_in    = (state_q == RECORD) && deser_done_i;
    full       = word_in && (wr_cnt_q == LastAddr);
    stop_rec   = (state_q == RECORD) && (record_i || full);
    stop_btn   = (state_q == PLAY) && play_i;
    end_play   = (state_q == PLAY) && rd_pend_q && rd_last_q;
    leave_play = stop_btn || end_play;
    pacer_en   = (state_q == PLAY) && !leave_play;
  end

  playback_pacer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WORD_PERIOD (WORD_PERIOD)
  ) u_pacer (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .clear_i   (start_play),
    .enable_i  (pacer_en),
    .length_i  (length_q),
    .read_o    (rd_strobe),
    .addr_o    (rd_addr),
    .last_o    (rd_last)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      addr_hold_q <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      length_q    <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
      deser_en_q  <= 1'b0;
    end else begin
      we_q <= word_in;
      if (word_in) begin
        wdata_q  <= deser_data_i;
        wr_cnt_q <= wr_cnt_q + (ADDR_WIDTH + 1)'(1);
      end
      // A stop press drops any read still in flight.
      rd_pend_q <= rd_strobe && !stop_btn;
      rd_last_q <= rd_last && !stop_btn;
      valid_q   <= rd_pend_q && !stop_btn;
      if (rd_pend_q && !stop_btn) begin
        sample_q <= mem_rdata_i;
      end

      unique case (state_q)
        IDLE: begin
          if (start_rec) begin
            state_q     <= RECORD;
            wr_cnt_q    <= '0;
            addr_hold_q <= '0;
            recording_q <= 1'b1;
            deser_en_q  <= 1'b1;
          end else if (start_play) begin
            state_q   <= PLAY;
            playing_q <= 1'b1;
          end
        end
        RECORD: begin
          addr_hold_q <= wr_cnt_q[ADDR_WIDTH-1:0];
          if (stop_rec) begin
            state_q     <= IDLE;
            recording_q <= 1'b0;
            deser_en_q  <= 1'b0;
            length_q    <= wr_cnt_q + (ADDR_WIDTH + 1)'(word_in);
          end
        end
        PLAY: begin
          addr_hold_q <= rd_addr;
          if (leave_play) begin
            state_q   <= IDLE;
            playing_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr_o = (state_q == PLAY) ? rd_addr : addr_hold_q;
  end

  assign deser_enable_o = deser_en_q;
  assign mem_we_o       = we_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_re_o       = rd_strobe;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign recording_o    = recording_q;
  assign playing_o      = playing_q;
  assign length_o       = length_q;

endmodule

// File: tb/tb_audio_record_controller.sv
// Directed bench for audio_record_controller with a small behavioural RAM (8 words).
module tb_audio_record_controller;

  localparam int unsigned AW = 3;
  localparam int unsigned WP = 16;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic          record_i;
  logic          play_i;
  logic          deser_enable_o;
  logic          deser_done_i;
  logic [15:0]   deser_data_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [15:0]   mem_wdata_o;
  logic          mem_re_o;
  logic [15:0]   mem_rdata_i;
  logic [15:0]   sample_o;
  logic          sample_valid_o;
  logic          recording_o;
  logic          playing_o;
  logic [AW:0]   length_o;

  logic [15:0]   ram [8];

  int checks = 0;
  int errors = 0;

  audio_record_controller #(
    .ADDR_WIDTH  (AW),
    .WORD_PERIOD (WP)
  ) dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .record_i       (record_i),
    .play_i         (play_i),
    .deser_enable_o (deser_enable_o),
    .deser_done_i   (deser_done_i),
    .deser_data_i   (deser_data_i),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_re_o       (mem_re_o),
    .mem_rdata_i    (mem_rdata_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .recording_o    (recording_o),
    .playing_o      (playing_o),
    .length_o       (length_o)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_record();
    record_i = 1'b1;
    tick();
    record_i = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] data);
    deser_done_i = 1'b1;
    deser_data_i = data;
    tick();
    deser_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int re_cyc[$];
    int re_adr[$];
    int v_cyc[$];
    logic [15:0] v_dat[$];
    logic [15:0] exp_words [4];
    int nvalid;
    int nre;

    exp_words[0] = 16'h1111;
    exp_words[1] = 16'h2222;
    exp_words[2] = 16'h3333;
    exp_words[3] = 16'h4444;
    mem_rdata_i  = '0;
    for (int i = 0; i < 8; i++) ram[i] = 16'h0000;

    // Reset state
    reset_n_i = 1'b0; record_i = 1'b0; play_i = 1'b0;
    deser_done_i = 1'b0; deser_data_i = '0;
    tick(); tick();
    check("rst_recording", recording_o, 0);
    check("rst_playing", playing_o, 0);
    check("rst_deser_en", deser_enable_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_re", mem_re_o, 0);
    check("rst_valid", sample_valid_o, 0);
    check("rst_length", length_o, 0);
    reset_n_i = 1'b1;
    tick();

    // Reset mid-record loses the recording
    pulse_record();
    for (int i = 0; i < 5; i++) write_word(16'h0F00 + 16'(i));
    check("midrec_recording", recording_o, 1);
    reset_n_i = 1'b0;
    #2;
    check("midrec_async_rec", recording_o, 0);
    tick();
    reset_n_i = 1'b1;
    tick();
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
    check("midrec_play_ignored", playing_o, 0);
    tick();
    check("midrec_play_ignored2", playing_o, 0);
    check("midrec_length", length_o, 0);

    // Record four words
    pulse_record();
    check("rec_recording", recording_o, 1);
    check("rec_deser_en", deser_enable_o, 1);
    check("rec_addr0", mem_addr_o, 0);
    for (int i = 0; i < 4; i++) begin
      write_word(exp_words[i]);
      check($sformatf("rec_we_%0d", i), mem_we_o, 1);
      check($sformatf("rec_addr_%0d", i), mem_addr_o, i);
      check($sformatf("rec_wdata_%0d", i), mem_wdata_o, exp_words[i]);
      tick();
      check($sformatf("rec_addr_inc_%0d", i), mem_addr_o, i + 1);
      check($sformatf("rec_we_low_%0d", i), mem_we_o, 0);
    end
    check("rec_length_held", length_o, 0);
    pulse_record();
    check("rec_stop_recording", recording_o, 0);
    check("rec_stop_deser_en", deser_enable_o, 0);
    check("rec_length", length_o, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rec_ram_%0d", i), ram[i], exp_words[i]);

    // Playback of that recording
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
    check("play_enter", playing_o, 1);
    c = 0;
    while (playing_o && c < 200) begin
      if (mem_re_o) begin re_cyc.push_back(c); re_adr.push_back(int'(mem_addr_o)); end
      if (sample_valid_o) begin v_cyc.push_back(c); v_dat.push_back(sample_o); end
      tick();
      c++;
    end
    if (sample_valid_o) begin v_cyc.push_back(c); v_dat.push_back(sample_o); end
    check("play_exit_cycle", c, 51);
    check("play_re_count", re_cyc.size(), 4);
    check("play_valid_count", v_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < re_cyc.size()) begin
        check($sformatf("play_re_cyc_%0d", i), re_cyc[i], 1 + 16 * i);
        check($sformatf("play_re_addr_%0d", i), re_adr[i], i);
      end
      if (i < v_cyc.size()) begin
        check($sformatf("play_valid_cyc_%0d", i), v_cyc[i], 3 + 16 * i);
        check($sformatf("play_sample_%0d", i), v_dat[i], exp_words[i]);
      end
    end
    tick();
    check("play_sample_hold", sample_o, 16'h4444);
    check("play_valid_low", sample_valid_o, 0);

    // Stop coinciding with a word
    pulse_record();
    write_word(16'h5550);
    write_word(16'h5551);
    deser_done_i = 1'b1;
    deser_data_i = 16'h5555;
    record_i = 1'b1;
    tick();
    deser_done_i = 1'b0;
    record_i = 1'b0;
    check("coinc_recording", recording_o, 0);
    check("coinc_we", mem_we_o, 1);
    check("coinc_addr", mem_addr_o, 2);
    check("coinc_wdata", mem_wdata_o, 16'h5555);
    check("coinc_length", length_o, 3);
    tick();
    check("coinc_ram2", ram[2], 16'h5555);

    // Fill the whole memory back-to-back
    pulse_record();
    for (int i = 0; i < 8; i++) begin
      deser_done_i = 1'b1;
      deser_data_i = 16'hA000 + 16'(i);
      tick();
    end
    check("full_recording", recording_o, 0);
    check("full_length", length_o, 8);
    check("full_we_last", mem_we_o, 1);
    check("full_addr_last", mem_addr_o, 7);
    deser_data_i = 16'hDEAD;
    tick();
    deser_done_i = 1'b0;
    check("full_9th_not_written", mem_we_o, 0);
    tick();
    for (int i = 0; i < 8; i++) check($sformatf("full_ram_%0d", i), ram[i], 16'hA000 + 16'(i));
    record_i = 1'b1;
    play_i = 1'b1;
    tick();
    record_i = 1'b0;
    play_i = 1'b0;
    check("both_recording", recording_o, 1);
    check("both_playing", playing_o, 0);
    write_word(16'hBEE0);
    write_word(16'hBEE1);
    pulse_record();
    check("short_length", length_o, 2);

    // Stop playback between reads; record presses ignored in PLAY
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      if (sample_valid_o) begin
        nvalid++;
        check("stop_first_sample", sample_o, 16'hBEE0);
      end
      record_i = (k == 5);
      tick();
    end
    record_i = 1'b0;
    check("stop_valid_before", nvalid, 1);
    check("stop_rec_ignored", recording_o, 0);
    check("stop_still_playing", playing_o, 1);
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
    check("stop_playing_low", playing_o, 0);
    nvalid = 0;
    nre = 0;
    for (int k = 0; k < 40; k++) begin
      if (sample_valid_o) nvalid++;
      if (mem_re_o) nre++;
      tick();
    end
    check("stop_no_valid", nvalid, 0);
    check("stop_no_read", nre, 0);
    check("stop_length_kept", length_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
